// File: rtl/vx_stream_mux_pkg.sv
// Shared constants for the stream multiplexer: output buffer stage encodings.
package vx_stream_mux_pkg;

  localparam int unsigned BUF_NONE = 0;
  localparam int unsigned BUF_PIPE = 1;
  localparam int unsigned BUF_SKID = 2;

endpackage

// File: rtl/vx_stream_mux_stage.sv
// Elastic register stage: a single pipe register (BUF_PIPE) or a main+skid pair (BUF_SKID).
module vx_stream_mux_stage
  import vx_stream_mux_pkg::*;
#(
  parameter int unsigned DATAW = 1,
  parameter int unsigned MODE  = BUF_PIPE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [DATAW-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [DATAW-1:0] data_o,
  input  logic             ready_i
);

  logic             valid_q, valid_d;
  logic [DATAW-1:0] data_q, data_d;

  if (MODE == BUF_SKID) begin : g_skid
    logic             skid_full_q, skid_full_d;
    logic [DATAW-1:0] skid_q, skid_d;
    logic             push, pop;

    // Ready comes straight from a flop, so upstream never sees ready_i combinationally.
    assign ready_o = !skid_full_q;
    assign push    = valid_i && !skid_full_q;
    assign pop     = valid_q && ready_i;

    always_comb begin
      valid_d     = valid_q;
      data_d      = data_q;
      skid_full_d = skid_full_q;
      skid_d      = skid_q;
      if (skid_full_q) begin
        if (pop) begin
          data_d      = skid_q;
          skid_full_d = 1'b0;
        end
      end else if (push) begin
        if (!valid_q || pop) begin
          valid_d = 1'b1;
          data_d  = data_i;
        end else begin
          skid_full_d = 1'b1;
          skid_d      = data_i;
        end
      end else if (pop) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        skid_full_q <= 1'b0;
        skid_q      <= '0;
      end else begin
        skid_full_q <= skid_full_d;
        skid_q      <= skid_d;
      end
    end
  end else begin : g_pipe
    assign ready_o = !valid_q || ready_i;

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o && valid_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else if (ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

`ifndef SYNTHESIS
  logic             held_q;
  logic [DATAW-1:0] held_data_q;

  // A stalled output must stay valid with unchanged data until it is taken.
  always_ff @(posedge clk) begin
    held_q      <= reset_n && valid_o && !ready_i;
    held_data_q <= data_o;
    if (reset_n && held_q) begin
      assert (valid_o && (data_o == held_data_q))
      else $error("valid_out dropped or data changed without a handshake");
    end
  end
`endif

endmodule

// File: rtl/vx_stream_mux.sv
// N-to-1 stream multiplexer with valid/ready flow control and an optional output buffer stage.
module vx_stream_mux
  import vx_stream_mux_pkg::*;
#(
  parameter int unsigned DATAW      = 1,
  parameter int unsigned N          = 1,
  parameter int unsigned SEL_ONEHOT = 0,
  parameter int unsigned LN         = $clog2(N),
  parameter int unsigned SELW       = (SEL_ONEHOT != 0) ? N : ((LN > 0) ? LN : 1),
  parameter int unsigned OUT_BUF    = BUF_PIPE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N-1:0]              valid_in,
  input  logic [N-1:0][DATAW-1:0]   data_in,
  output logic [N-1:0]              ready_in,
  input  logic [SELW-1:0]           sel_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  input  logic                      ready_out
);

  logic [N-1:0]     sel_hit;
  logic             sel_valid;
  logic [DATAW-1:0] sel_data;
  logic             accept;

  if (N == 1) begin : g_single
    logic unused_sel;
    assign unused_sel = ^sel_in;
    assign sel_hit    = 1'b1;
  end else if (SEL_ONEHOT != 0) begin : g_onehot
    assign sel_hit = N'(sel_in);
  end else begin : g_binary
    // Out-of-range binary selects match no channel.
    always_comb begin
      sel_hit = '0;
      for (int i = 0; i < int'(N); i++) begin
        sel_hit[i] = (sel_in == SELW'(i));
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel_hit[i]) begin
        sel_valid = sel_valid | valid_in[i];
        sel_data  = sel_data | data_in[i];
      end
    end
  end

  if (OUT_BUF == BUF_NONE) begin : g_none
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign accept         = ready_out;
    assign valid_out      = sel_valid;
    assign data_out       = sel_data;
    assign ready_in       = sel_hit & {N{accept}};
  end else begin : g_buf
    vx_stream_mux_stage #(
      .DATAW (DATAW),
      .MODE  (OUT_BUF)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .valid_i (sel_valid),
      .data_i  (sel_data),
      .ready_o (accept),
      .valid_o (valid_out),
      .data_o  (data_out),
      .ready_i (ready_out)
    );
    // No channel may complete a transfer while reset is held.
    assign ready_in = reset_n ? (sel_hit & {N{accept}}) : '0;
  end

`ifndef SYNTHESIS
  if (SEL_ONEHOT != 0 && N > 1) begin : g_sel_chk
    always_ff @(posedge clk) begin
      if (reset_n) begin
        assert ($countones(sel_in) <= 1)
        else $error("one-hot sel_in has more than one bit set");
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_stream_mux.sv
// Randomized scoreboard bench for vx_stream_mux across buffer modes, select modes and widths.
module tb_vx_stream_mux;

  localparam int NCFG = 6;
  localparam int NCYC = 600;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit rst_sched(input int k);
    return (k < 2) || (k == 300) || (k == 301);
  endfunction

  function automatic bit stall_sched(input int k);
    return (k >= 100 && k < 110) || (k >= 290 && k < 302);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // cfg0: N=4 bin pipe, cfg1: N=4 bin skid, cfg2: N=4 one-hot skid,
  // cfg3: N=4 bin none, cfg4: N=1 none, cfg5: N=1 skid
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned CN = (g >= 4) ? 1 : 4;
    localparam bit          OH = (g == 2);
    localparam int unsigned OB = (g == 0) ? 1 : (g == 1 || g == 2 || g == 5) ? 2 : 0;
    localparam int unsigned SW = OH ? CN : ((CN > 1) ? $clog2(CN) : 1);

    logic [CN-1:0]        valid_in;
    logic [CN-1:0][7:0]   data_in;
    logic [CN-1:0]        ready_in;
    logic [SW-1:0]        sel_in;
    logic                 valid_out;
    logic [7:0]           data_out;
    logic                 ready_out;
    logic [CN-1:0]        exp_ready;
    logic [8:0]           exp_q[$];

    vx_stream_mux #(
      .DATAW      (8),
      .N          (CN),
      .SEL_ONEHOT (OH ? 1 : 0),
      .OUT_BUF    (OB)
    ) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .ready_in  (ready_in),
      .sel_in    (sel_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .ready_out (ready_out)
    );

    // Driver and reference model: the buffer is just a FIFO of capacity OB.
    initial begin
      bit         xfer_prev;
      bit         rst_prev;
      bit         acc;
      bit         vs;
      bit         rst_low;
      bit         stall;
      logic [7:0] d_prev;
      logic [31:0] sel_w;
      int         s;
      int         r;
      xfer_prev = 1'b0;
      rst_prev  = 1'b0;
      d_prev    = '0;
      valid_in  = '0;
      data_in   = '0;
      sel_in    = '0;
      ready_out = 1'b0;
      exp_ready = '0;
      for (int k = 0; k < NCYC; k++) begin
        @(posedge clk);
        #1;
        if (OB != 0) begin
          if (rst_prev) exp_q.delete();
          else if (xfer_prev) exp_q.push_back({1'b1, d_prev});
        end
        stall   = stall_sched(k);
        rst_low = rst_sched(k);
        valid_in = stall ? '1 : CN'($urandom);
        for (int i = 0; i < int'(CN); i++) data_in[i] = 8'($urandom);
        if (OH) begin
          r = stall ? 1 : int'($urandom_range(0, CN));
          sel_in = '0;
          if (r < int'(CN)) sel_in[r] = 1'b1;
        end else begin
          sel_in = stall ? SW'(1) : SW'($urandom);
        end
        ready_out = stall ? 1'b0 : ($urandom_range(0, 9) < 6);

        sel_w = 32'(sel_in);
        if (CN == 1) s = 0;
        else if (OH) begin
          s = -1;
          for (int i = 0; i < int'(CN); i++) if (sel_w[i]) s = i;
        end else s = (sel_w < CN) ? int'(sel_w) : -1;
        vs = (s >= 0) && valid_in[s];

        exp_ready = '0;
        if (OB == 0) begin
          if (s >= 0 && ready_out) exp_ready[s] = 1'b1;
          exp_q.push_back({vs, vs ? data_in[s] : 8'h00});
        end else begin
          if (rst_low) acc = 1'b0;
          else if (OB == 1) acc = (exp_q.size() == 0) || ready_out;
          else acc = (exp_q.size() < 2);
          if (s >= 0 && acc) exp_ready[s] = 1'b1;
          xfer_prev = vs && acc;
          if (s >= 0) d_prev = data_in[s];
          rst_prev = rst_low;
        end
      end
    end

    // Monitor: compares DUT outputs against the scoreboard queue mid-cycle.
    initial begin
      bit         prev_rst;
      logic [8:0] e;
      prev_rst = 1'b0;
      forever begin
        @(negedge clk);
        check($sformatf("c%0d ready_in", g), 32'(ready_in), 32'(exp_ready));
        if (OB == 0) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("c%0d valid_out", g), 32'(valid_out), 32'(e[8]));
            if (e[8]) check($sformatf("c%0d data_out", g), 32'(data_out), 32'(e[7:0]));
          end
        end else begin
          check($sformatf("c%0d valid_out", g), 32'(valid_out), 32'(exp_q.size() > 0));
          if (prev_rst) check($sformatf("c%0d reset data_out", g), 32'(data_out), 32'(0));
          if (valid_out && exp_q.size() > 0) begin
            check($sformatf("c%0d data_out", g), 32'(data_out), 32'(exp_q[0][7:0]));
            if (ready_out) e = exp_q.pop_front();
          end
        end
        prev_rst = !rst_n;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      rst_n = !rst_sched(k);
    end
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
